// File: rtl/mface_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mface_ctrl : Multiface-style NMI freezer; pages cartridge ROM/RAM on NMI ack.
// Define MFACE_SNOOP_EN to mirror write-only CPC HW registers into cartridge RAM.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mface_ctrl #(
    parameter int          RAM_AW    = 13,
    parameter int          ROM_AW    = 13,
    parameter logic [15:0] NMI_VEC   = 16'h0066,
    parameter logic [15:0] HIDE_VEC  = 16'h0065,
    parameter logic [13:0] PORT_BASE = 14'h3FBA,
    parameter int          CRTC_REGS = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              key_nmi,
    input  logic [15:0]       cpu_addr,
    input  logic              m1,
    input  logic              io_wr,
    input  logic [7:0]        io_dout,
    input  logic              mem_wr,
    input  logic [7:0]        mem_din,
    output logic              nmi,
    output logic              mf_en,
    output logic              rom_en,
    output logic              ram_en,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [7:0]        ram_dout
);
    localparam logic [16:0] RAM_LO  = 17'h02000;
    localparam logic [16:0] RAM_TOP = RAM_LO + (17'd1 << RAM_AW);
    localparam logic [16:0] ROM_TOP = 17'd1 << ROM_AW;

    typedef enum logic [2:0] {
        S_OFF, S_ARMED, S_ON, S_ON_HIDDEN, S_OFF_HIDDEN
    } state_t;

    state_t state, state_nx;

    logic key_q, m1_q, io_wr_q;
    logic key_rise, m1_rise, io_rise;
    logic port_hit, page_on, page_off;
    logic [16:0] addr17;

    // Edge detectors run through reset so a key held across reset is not a new rise.
    always_ff @(posedge clk_sys) begin
        key_q   <= key_nmi;
        m1_q    <= m1;
        io_wr_q <= io_wr;
    end

    assign key_rise = key_nmi & ~key_q;
    assign m1_rise  = m1 & ~m1_q;
    assign io_rise  = io_wr & ~io_wr_q;
    assign port_hit = io_rise && (cpu_addr[15:2] == PORT_BASE);
    assign page_on  = port_hit & ~cpu_addr[1];
    assign page_off = port_hit & cpu_addr[1];

    always_ff @(posedge clk_sys) begin
        if (reset) state <= S_OFF;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        nmi      = 1'b0;
        mf_en    = 1'b0;
        case (state)
            S_OFF: begin
                if (key_rise)     state_nx = S_ARMED;
                else if (page_on) state_nx = S_ON;
            end
            S_ARMED: begin
                nmi = 1'b1;
                if (m1_rise && cpu_addr == NMI_VEC) state_nx = S_ON;
            end
            S_ON: begin
                mf_en = 1'b1;
                if (page_off)                             state_nx = S_OFF;
                else if (m1_rise && cpu_addr == HIDE_VEC) state_nx = S_ON_HIDDEN;
            end
            S_ON_HIDDEN: begin
                mf_en = 1'b1;
                if (page_off) state_nx = S_OFF_HIDDEN;
            end
            S_OFF_HIDDEN: begin
                if (key_rise) state_nx = S_ARMED;
            end
            default: state_nx = S_OFF;
        endcase
    end

    assign addr17   = {1'b0, cpu_addr};
    assign rom_en   = mf_en && (addr17 < ROM_TOP);
    assign ram_en   = mf_en && (addr17 >= RAM_LO) && (addr17 < RAM_TOP);
    assign rom_addr = cpu_addr[ROM_AW-1:0];

    logic              we;
    logic [RAM_AW-1:0] wa;
    logic [7:0]        wd;

`ifdef MFACE_SNOOP_EN
    localparam int                CRTC_W    = $clog2(CRTC_REGS);
    localparam logic [RAM_AW-1:0] SNOOP_TOP = {RAM_AW{1'b1}} << 13;

    logic [4:0]        pen;
    logic [CRTC_W-1:0] crtc_sel;
    logic              snoop_we;
    logic [12:0]       snoop_a;

    always_comb begin
        snoop_we = io_rise;
        snoop_a  = 13'h0000;
        case (cpu_addr[15:8])
            8'h7F: begin
                case (io_dout[7:6])
                    2'b00:   snoop_a = 13'h1FCF;
                    2'b01:   snoop_a = pen[4] ? 13'h1FDF : {9'h1F9, pen[3:0]};
                    2'b10:   snoop_a = 13'h1FEF;
                    default: snoop_a = 13'h1FFF;
                endcase
            end
            8'hBC:   snoop_a = 13'h1CFF;
            8'hBD:   snoop_a = 13'h1DB0 + 13'(crtc_sel);
            8'hF7:   snoop_a = 13'h17FF;
            8'hDF:   snoop_a = 13'h1AAC;
            default: snoop_we = 1'b0;
        endcase
    end

    // Gate-array pen and CRTC index latches; crtc_sel keeps only its low bits so it wraps.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pen      <= 5'd0;
            crtc_sel <= '0;
        end else if (io_rise) begin
            if (cpu_addr[15:8] == 8'h7F && io_dout[7:6] == 2'b00) pen <= io_dout[4:0];
            if (cpu_addr[15:8] == 8'hBC) crtc_sel <= io_dout[CRTC_W-1:0];
        end
    end
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, io_dout};
`endif

    always_comb begin
        we = 1'b0;
        wa = cpu_addr[RAM_AW-1:0];
        wd = mem_din;
        if (mem_wr && ram_en) we = 1'b1;
`ifdef MFACE_SNOOP_EN
        if (snoop_we) begin
            we = 1'b1;
            wa = SNOOP_TOP | RAM_AW'(snoop_a);
            wd = io_dout;
        end
`endif
    end

    logic [7:0] mem [0:(1<<RAM_AW)-1];

    always_ff @(posedge clk_sys) begin
        if (we) mem[wa] <= wd;
    end

    always_ff @(posedge clk_sys) begin
        if (reset)   ram_dout <= 8'h00;
        else if (we) ram_dout <= wd;
        else         ram_dout <= mem[cpu_addr[RAM_AW-1:0]];
    end

endmodule
`default_nettype wire

// File: tb/tb_mface_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mface_ctrl : scoreboard bench for mface_ctrl paging, NMI and RAM mirroring.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mface_ctrl;
`ifdef MFACE_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif
    localparam logic [2:0] K_DOUT = 3'd0, K_NMI = 3'd1, K_MF = 3'd2, K_ROM = 3'd3, K_RAM = 3'd4;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        key_nmi = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        m1 = 1'b0;
    logic        io_wr = 1'b0;
    logic [7:0]  io_dout = 8'h00;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din = 8'h00;
    logic        nmi, mf_en, rom_en, ram_en;
    logic [12:0] rom_addr;
    logic [7:0]  ram_dout;

    mface_ctrl dut (
        .clk_sys(clk_sys), .reset(reset), .key_nmi(key_nmi), .cpu_addr(cpu_addr),
        .m1(m1), .io_wr(io_wr), .io_dout(io_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .nmi(nmi), .mf_en(mf_en), .rom_en(rom_en), .ram_en(ram_en),
        .rom_addr(rom_addr), .ram_dout(ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed { logic [2:0] kind; logic [7:0] val; } exp_t;
    exp_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad = 0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] kind, input string tag, input logic [7:0] val);
        exp_q.push_back('{kind: kind, val: val});
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        exp_t       e;
        string      t;
        logic [7:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            case (e.kind)
                K_DOUT:  obs = ram_dout;
                K_NMI:   obs = {7'd0, nmi};
                K_MF:    obs = {7'd0, mf_en};
                K_ROM:   obs = {7'd0, rom_en};
                default: obs = {7'd0, ram_en};
            endcase
            check_val(t, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
        drain();
    endtask

    task automatic expect_state(input string tag, input logic n, input logic m);
        push(K_NMI, {tag, ".nmi"}, {7'd0, n});
        push(K_MF, {tag, ".mf_en"}, {7'd0, m});
        step();
    endtask

    task automatic out_io(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; io_dout = d; io_wr = 1'b1;
        step();
        io_wr = 1'b0;
        step();
    endtask

    task automatic m1_fetch(input logic [15:0] a);
        cpu_addr = a; m1 = 1'b1;
        step();
        m1 = 1'b0;
        step();
    endtask

    task automatic cpu_write(input string tag, input logic [15:0] a, input logic [7:0] d,
                             input logic [7:0] exp_dout);
        cpu_addr = a; mem_din = d; mem_wr = 1'b1;
        push(K_DOUT, tag, exp_dout);
        step();
        mem_wr = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
        cpu_addr = a;
        push(K_DOUT, tag, exp);
        step();
    endtask

    initial begin
        repeat (2) step();
        push(K_DOUT, "rst.dout", 8'h00);
        expect_state("rst", 1'b0, 1'b0);
        reset = 1'b0;
        expect_state("idle", 1'b0, 1'b0);

        key_nmi = 1'b1;
        step();
        key_nmi = 1'b0;
        expect_state("armed", 1'b1, 1'b0);
        out_io(16'hFEE8, 8'h00);
        expect_state("armed_port_on", 1'b1, 1'b0);
        out_io(16'hFEEA, 8'h00);
        expect_state("armed_port_off", 1'b1, 1'b0);
        m1_fetch(16'h0067);
        expect_state("armed_wrong_vec", 1'b1, 1'b0);
        m1_fetch(16'h0066);
        expect_state("nmi_ack", 1'b0, 1'b1);

        cpu_addr = 16'h0100;
        push(K_ROM, "rom_win.rom", 8'h01);
        push(K_RAM, "rom_win.ram", 8'h00);
        step();
        cpu_addr = 16'h2010;
        push(K_ROM, "ram_win.rom", 8'h00);
        push(K_RAM, "ram_win.ram", 8'h01);
        step();
        cpu_addr = 16'h4000;
        push(K_RAM, "above_ram.ram", 8'h00);
        step();

        cpu_write("wr_first", 16'h2010, 8'hA5, 8'hA5);
        cpu_write("pre_dbc", 16'h3DBC, 8'h11, 8'h11);
        cpu_write("pre_dbd", 16'h3DBD, 8'h44, 8'h44);
        cpu_write("pre_fcf", 16'h3FCF, 8'h22, 8'h22);
        cpu_write("pre_f93", 16'h3F93, 8'h33, 8'h33);
        cpu_read("rd_2010", 16'h2010, 8'hA5);

        out_io(16'h7F00, 8'h03);
        out_io(16'h7F00, 8'h54);
        out_io(16'hBC00, 8'h0C);
        out_io(16'hBD00, 8'h30);
        out_io(16'hBC00, 8'h1D);
        out_io(16'hBD00, 8'h77);
        expect_state("after_snoop", 1'b0, 1'b1);
        cpu_read("snoop_pen_sel", 16'h3FCF, SNOOP ? 8'h03 : 8'h22);
        cpu_read("snoop_ink", 16'h3F93, SNOOP ? 8'h54 : 8'h33);
        cpu_read("snoop_crtc", 16'h3DBC, SNOOP ? 8'h30 : 8'h11);
        cpu_read("snoop_crtc_wrap", 16'h3DBD, SNOOP ? 8'h77 : 8'h44);
        cpu_read("rd_2010_again", 16'h2010, 8'hA5);

        m1_fetch(16'h0065);
        expect_state("hidden_on", 1'b0, 1'b1);
        out_io(16'hFEEA, 8'h00);
        expect_state("hidden_off", 1'b0, 1'b0);
        out_io(16'hFEE8, 8'h00);
        expect_state("hidden_blocks_on", 1'b0, 1'b0);
        push(K_RAM, "off_wr.ram_en", 8'h00);
        cpu_write("off_wr_blocked", 16'h2010, 8'h5A, 8'hA5);

        key_nmi = 1'b1;
        step();
        key_nmi = 1'b0;
        expect_state("rearm_from_hidden", 1'b1, 1'b0);
        m1_fetch(16'h0066);
        expect_state("ack2", 1'b0, 1'b1);
        cpu_read("off_wr_check", 16'h2010, 8'hA5);

        out_io(16'hFEEA, 8'h00);
        expect_state("port_off", 1'b0, 1'b0);
        out_io(16'hFEE8, 8'h00);
        expect_state("port_on", 1'b0, 1'b1);
        key_nmi = 1'b1;
        step();
        key_nmi = 1'b0;
        expect_state("key_in_on", 1'b0, 1'b1);

        out_io(16'hFEEA, 8'h00);
        key_nmi = 1'b1;
        step();
        expect_state("armed_again", 1'b1, 1'b0);
        reset = 1'b1;
        expect_state("rst_in_armed", 1'b0, 1'b0);
        reset = 1'b0;
        expect_state("key_held", 1'b0, 1'b0);
        step();
        expect_state("key_held2", 1'b0, 1'b0);
        key_nmi = 1'b0;
        step();
        key_nmi = 1'b1;
        step();
        expect_state("new_rise", 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
